regfile_multiport: RTL and testbench
====================================

Name: regfile_multiport

Overview:
Parametrised general-purpose register file for the multi-cycle and follow-on CPUs. Provides a configurable number of read ports, a byte-enabled write port with optional write-through bypass, and a hardwired zero register. It also has a sequential bulk-clear engine driven by a request/busy/done handshake, and a display tap that either follows a selector or auto-scans all registers for the board's 7-segment driver.

Parameters:
DATA_W, 32, register width in bits (multiple of 8)
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
DISP_W, 16, display tap width (<= DATA_W), low bits of the entry
SCAN_DIV, 50000000, clk cycles per auto-scan step (>= 1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
we  in  1  write enable
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
wbe  in  DATA_W/8  byte enables; byte b written when wbe[b]=1
raddr  in  NUM_RD*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  read data, port p at [p*DATA_W +: DATA_W]
clr_req  in  1  bulk-clear request (level sampled)
clr_busy  out  1  clear in progress
clr_done  out  1  one-cycle pulse on clear completion
disp_auto  in  1  1 = auto-scan, 0 = manual select
disp_sel  in  ADDR_W  manual display register index
disp_idx  out  ADDR_W  index currently shown
disp_data  out  DISP_W  entry[disp_idx][DISP_W-1:0]

Behaviour:
- Reset, asynchronous, acts immediately: all entries 0, clear FSM in IDLE, clr_busy=0, clr_done=0, disp_idx=0, scan prescaler 0. Reset mid-clear aborts the clear; clr_done is not pulsed.
- Write: on a clk edge with we=1 and state IDLE, each byte with wbe[b]=1 takes wdata's byte b. Other bytes are kept. Writes to entry 0 are discarded when ZERO_REG=1. wbe=0 means no change.
- Read: combinational, zero latency. With ZERO_REG=1, raddr=0 returns 0. With BYPASS=1, we=1, state IDLE and raddr==waddr (not 0 when ZERO_REG), the port returns the stored word with enabled bytes replaced by wdata, i.e. the post-write value. With BYPASS=0 it returns the pre-write value.
- Clear FSM states:
  - IDLE: clr_req=1 at an edge → CLEAR, idx=0.
  - CLEAR: each edge sets entry[idx]=0. At idx=DEPTH-1 → DONE, otherwise idx+1.
  - DONE: one cycle, then → IDLE.
  - clr_busy=(state==CLEAR), so it is high for exactly DEPTH cycles. clr_done=(state==DONE).
  - clr_req is ignored outside IDLE. A request still high in the IDLE cycle after DONE starts a new clear.
- Writes presented while state≠IDLE are dropped silently. Reads stay live during a clear and reflect partially cleared contents. Bypass is inactive while state≠IDLE.
- Display, registered, updates on clk:
  - disp_auto=0: disp_idx<=disp_sel, prescaler held at 0.
  - disp_auto=1: the prescaler counts 0..SCAN_DIV-1. When it wraps, disp_idx<=disp_idx+1 mod DEPTH, wrapping DEPTH-1→0.
  - Switching into auto starts from the current disp_idx.
  - disp_data is combinational from disp_idx and storage. Entry 0 shows 0 when ZERO_REG=1.

Decomposition:
- Package regfile_pkg: FSM state encoding (ST_IDLE, ST_CLEAR, ST_DONE), the byte-merge function used by both write and bypass, and the derived localparams NBYTE=DATA_W/8 and DEPTH.
- Sub-module regfile_disp_scan: prescaler, disp_idx register and auto/manual mux.
- Storage, read ports and the clear FSM stay in the top.

Test Plan:
- Reset, then write wdata=32'hDEADBEEF, wbe=4'hF to r5; read port 0 raddr=5 next cycle → 32'hDEADBEEF. Write to r0 → raddr=0 reads 0.
- r7=32'h11223344, then write wdata=32'hAABBCCDD with wbe=4'b0101 → r7=32'h11BB33DD. Same cycle with BYPASS=1: port 1 raddr=7 already reads 32'h11BB33DD.
- Fill all entries with their index, pulse clr_req one cycle → clr_busy high exactly 32 cycles, then clr_done high 1 cycle. All entries read 0. A write of 32'h5 to r3 issued mid-clear is absent afterwards.
- Assert reset at clear cycle 10 → clr_busy=0 immediately, no clr_done pulse, all entries 0, a subsequent write succeeds.
- SCAN_DIV=4, disp_auto=1, r1=32'h00001234 → disp_idx advances every 4 cycles 0,1,2…31,0. disp_data=16'h1234 while disp_idx=1.
- disp_auto=0, disp_sel=29 → disp_idx=29 one cycle later, disp_data = r29[15:0].

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file:
// clear FSM encoding, default geometry and the byte-merge used by write and bypass paths.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int NBYTE      = DEF_DATA_W / 8;
    localparam int DEPTH      = 2 ** DEF_ADDR_W;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MAX_W  = 256;
    localparam int MAX_NB = MAX_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DONE
    } clr_state_t;

    function automatic logic [MAX_W-1:0] byte_merge(
        input logic [MAX_W-1:0]  i_old,
        input logic [MAX_W-1:0]  i_new,
        input logic [MAX_NB-1:0] i_be
    );
        logic [MAX_W-1:0] v_word;
        v_word = i_old;
        for (int unsigned b = 0; b < MAX_NB; b++) begin
            if (i_be[b]) v_word[b*8 +: 8] = i_new[b*8 +: 8];
        end
        return v_word;
    endfunction

endpackage

// File: rtl/regfile_disp_scan.sv
// Display index generator: follows a manual selector, or steps through all
// entries once every SCAN_DIV clocks when auto-scan is enabled.
module regfile_disp_scan #(
    parameter int ADDR_W   = 5,
    parameter int SCAN_DIV = 50000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_auto,
    input  logic [ADDR_W-1:0] i_sel,
    output logic [ADDR_W-1:0] o_idx
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0]     r_pre;
    logic [ADDR_W-1:0] r_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (!i_auto) begin
            r_pre <= '0;
            r_idx <= i_sel;
        end else if (r_pre == PW'(SCAN_DIV - 1)) begin
            // Index wraps naturally from DEPTH-1 to 0.
            r_pre <= '0;
            r_idx <= r_idx + 1'b1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    assign o_idx = r_idx;

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port register file with byte-enabled write, optional write-through
// bypass, hardwired zero entry, sequential bulk clear and a display tap.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int DISP_W   = 16,
    parameter int SCAN_DIV = 50000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/8-1:0]      wbe,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done,
    input  logic                     disp_auto,
    input  logic [ADDR_W-1:0]        disp_sel,
    output logic [ADDR_W-1:0]        disp_idx,
    output logic [DISP_W-1:0]        disp_data
);

    localparam int NENT = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [NENT];
    clr_state_t        r_state;
    logic [ADDR_W-1:0] r_clr_idx;
    logic              r_clr_busy;
    logic              r_clr_done;

    logic              w_wr_ok;
    logic [MAX_W-1:0]  w_merged_full;
    logic [DATA_W-1:0] w_merged;
    logic [ADDR_W-1:0] w_disp_idx;

    // Entry 0 writes are discarded up front so bypass never forwards them either.
    assign w_wr_ok = we && (r_state == ST_IDLE) && !((ZERO_REG != 0) && (waddr == '0));

    assign w_merged_full = byte_merge(MAX_W'(r_mem[waddr]), MAX_W'(wdata), MAX_NB'(wbe));
    assign w_merged      = w_merged_full[DATA_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NENT; i++) r_mem[i] <= '0;
            r_state    <= ST_IDLE;
            r_clr_idx  <= '0;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_ok) r_mem[waddr] <= w_merged;
                    if (clr_req) begin
                        r_state    <= ST_CLEAR;
                        r_clr_idx  <= '0;
                        r_clr_busy <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_mem[r_clr_idx] <= '0;
                    if (r_clr_idx == '1) begin
                        r_state    <= ST_DONE;
                        r_clr_busy <= 1'b0;
                        r_clr_done <= 1'b1;
                    end else begin
                        r_clr_idx <= r_clr_idx + 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_clr_done <= 1'b0;
                end
            endcase
        end
    end

    assign clr_busy = r_clr_busy;
    assign clr_done = r_clr_done;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;

        assign w_ra = raddr[p*ADDR_W +: ADDR_W];

        always_comb begin
            w_rd = r_mem[w_ra];
            if ((ZERO_REG != 0) && (w_ra == '0)) begin
                w_rd = '0;
            end else if ((BYPASS != 0) && w_wr_ok && (w_ra == waddr)) begin
                w_rd = w_merged;
            end
        end

        assign rdata[p*DATA_W +: DATA_W] = w_rd;
    end

    regfile_disp_scan #(
        .ADDR_W   (ADDR_W),
        .SCAN_DIV (SCAN_DIV)
    ) u_disp (
        .clk    (clk),
        .reset  (reset),
        .i_auto (disp_auto),
        .i_sel  (disp_sel),
        .o_idx  (w_disp_idx)
    );

    assign disp_idx = w_disp_idx;

    always_comb begin
        disp_data = r_mem[w_disp_idx][DISP_W-1:0];
        if ((ZERO_REG != 0) && (w_disp_idx == '0)) disp_data = '0;
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: writes, byte enables, bypass, bulk clear,
// reset during clear and the display tap in manual and auto-scan modes.
module tb_regfile_multiport;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DISP_W = 16;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     we = 1'b0;
    logic [ADDR_W-1:0]        waddr = '0;
    logic [DATA_W-1:0]        wdata = '0;
    logic [DATA_W/8-1:0]      wbe = '0;
    logic [NUM_RD*ADDR_W-1:0] raddr = '0;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic                     clr_req = 1'b0;
    logic                     clr_busy;
    logic                     clr_done;
    logic                     disp_auto = 1'b0;
    logic [ADDR_W-1:0]        disp_sel = '0;
    logic [ADDR_W-1:0]        disp_idx;
    logic [DISP_W-1:0]        disp_data;

    int n_cmp = 0;
    int n_err = 0;

    regfile_multiport #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (1),
        .BYPASS   (1),
        .DISP_W   (DISP_W),
        .SCAN_DIV (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .wbe       (wbe),
        .raddr     (raddr),
        .rdata     (rdata),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .disp_auto (disp_auto),
        .disp_sel  (disp_sel),
        .disp_idx  (disp_idx),
        .disp_data (disp_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input logic [3:0] be);
        we = 1'b1; waddr = a; wdata = d; wbe = be;
        tick();
        we = 1'b0; wbe = '0;
    endtask

    task automatic test_reset();
        do_reset();
        raddr[0 +: ADDR_W] = 5'd5;
        raddr[ADDR_W +: ADDR_W] = 5'd31;
        #1;
        n_cmp++; if (clr_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", clr_busy); end
        n_cmp++; if (clr_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", clr_done); end
        n_cmp++; if (disp_idx !== 5'd0) begin n_err++; $display("FAIL reset_disp_idx got %0d want 0", disp_idx); end
        n_cmp++; if (rdata !== 64'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", rdata); end
    endtask

    task automatic test_write_read();
        write_word(5'd5, 32'hDEADBEEF, 4'hF);
        raddr[0 +: ADDR_W] = 5'd5;
        #1;
        n_cmp++; if (rdata[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL read_r5 got %h want deadbeef", rdata[31:0]); end
        // Same-cycle write to r0 must not be forwarded, then must not stick.
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; wbe = 4'hF;
        raddr[0 +: ADDR_W] = 5'd0;
        #1;
        n_cmp++; if (rdata[31:0] !== 32'h0) begin n_err++; $display("FAIL r0_bypass got %h want 0", rdata[31:0]); end
        tick();
        we = 1'b0;
        #1;
        n_cmp++; if (rdata[31:0] !== 32'h0) begin n_err++; $display("FAIL r0_read got %h want 0", rdata[31:0]); end
    endtask

    task automatic test_byte_enable_bypass();
        write_word(5'd7, 32'h11223344, 4'hF);
        we = 1'b1; waddr = 5'd7; wdata = 32'hAABBCCDD; wbe = 4'b0101;
        raddr[ADDR_W +: ADDR_W] = 5'd7;
        raddr[0 +: ADDR_W] = 5'd5;
        #1;
        n_cmp++; if (rdata[63:32] !== 32'h11BB33DD) begin n_err++; $display("FAIL bypass_p1 got %h want 11bb33dd", rdata[63:32]); end
        n_cmp++; if (rdata[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL bypass_other got %h want deadbeef", rdata[31:0]); end
        tick();
        we = 1'b0; wbe = '0;
        raddr[0 +: ADDR_W] = 5'd7;
        #1;
        n_cmp++; if (rdata[31:0] !== 32'h11BB33DD) begin n_err++; $display("FAIL be_merge got %h want 11bb33dd", rdata[31:0]); end
        write_word(5'd7, 32'h99999999, 4'b0000);
        #1;
        n_cmp++; if (rdata[31:0] !== 32'h11BB33DD) begin n_err++; $display("FAIL be_zero got %h want 11bb33dd", rdata[31:0]); end
    endtask

    task automatic test_clear();
        int busy_cnt;
        int nz;
        bit early_done;
        for (int i = 0; i < 32; i++) write_word(ADDR_W'(i), DATA_W'(i), 4'hF);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_cnt = 0;
        early_done = 1'b0;
        while (clr_busy === 1'b1 && busy_cnt < 100) begin
            if (clr_done === 1'b1) early_done = 1'b1;
            if (busy_cnt == 10) begin
                we = 1'b1; waddr = 5'd3; wdata = 32'h5; wbe = 4'hF;
                raddr[0 +: ADDR_W] = 5'd3;
                raddr[ADDR_W +: ADDR_W] = 5'd20;
                #1;
                n_cmp++; if (rdata[31:0] !== 32'h0) begin n_err++; $display("FAIL clear_no_bypass got %h want 0", rdata[31:0]); end
                n_cmp++; if (rdata[63:32] !== 32'd20) begin n_err++; $display("FAIL clear_partial got %h want 14", rdata[63:32]); end
            end
            busy_cnt++;
            tick();
            we = 1'b0;
        end
        n_cmp++; if (busy_cnt != 32) begin n_err++; $display("FAIL clear_busy_len got %0d want 32", busy_cnt); end
        n_cmp++; if (early_done !== 1'b0) begin n_err++; $display("FAIL clear_done_early got %b want 0", early_done); end
        n_cmp++; if (clr_done !== 1'b1) begin n_err++; $display("FAIL clear_done_pulse got %b want 1", clr_done); end
        tick();
        n_cmp++; if ({clr_busy, clr_done} !== 2'b00) begin n_err++; $display("FAIL clear_after got %b want 00", {clr_busy, clr_done}); end
        nz = 0;
        for (int i = 0; i < 32; i++) begin
            raddr[0 +: ADDR_W] = ADDR_W'(i);
            #1;
            if (rdata[31:0] !== 32'h0) nz++;
        end
        n_cmp++; if (nz != 0) begin n_err++; $display("FAIL clear_contents got %0d nonzero want 0", nz); end
    endtask

    task automatic test_back_to_back();
        int guard;
        clr_req = 1'b1;
        tick();
        guard = 0;
        while (clr_done !== 1'b1 && guard < 100) begin guard++; tick(); end
        n_cmp++; if (guard >= 100) begin n_err++; $display("FAIL b2b_timeout got %0d cycles want <100", guard); end
        tick();
        n_cmp++; if (clr_busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle got %b want 0", clr_busy); end
        tick();
        clr_req = 1'b0;
        n_cmp++; if (clr_busy !== 1'b1) begin n_err++; $display("FAIL b2b_restart got %b want 1", clr_busy); end
        guard = 0;
        while (clr_done !== 1'b1 && guard < 100) begin guard++; tick(); end
        tick();
    endtask

    task automatic test_reset_mid_clear();
        bit seen_done;
        write_word(5'd31, 32'd31, 4'hF);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        raddr[0 +: ADDR_W] = 5'd31;
        reset = 1'b1;
        #1;
        n_cmp++; if (clr_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %b want 0", clr_busy); end
        n_cmp++; if (rdata[31:0] !== 32'h0) begin n_err++; $display("FAIL rst_mid_r31 got %h want 0", rdata[31:0]); end
        @(negedge clk);
        reset = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin tick(); if (clr_done === 1'b1) seen_done = 1'b1; end
        n_cmp++; if (seen_done !== 1'b0) begin n_err++; $display("FAIL rst_mid_done got %b want 0", seen_done); end
        write_word(5'd4, 32'hCAFEF00D, 4'hF);
        raddr[0 +: ADDR_W] = 5'd4;
        #1;
        n_cmp++; if (rdata[31:0] !== 32'hCAFEF00D) begin n_err++; $display("FAIL rst_mid_write got %h want cafef00d", rdata[31:0]); end
    endtask

    task automatic test_manual_disp();
        write_word(5'd29, 32'h89ABCDEF, 4'hF);
        disp_auto = 1'b0;
        disp_sel = 5'd29;
        tick();
        n_cmp++; if (disp_idx !== 5'd29) begin n_err++; $display("FAIL disp_sel_idx got %0d want 29", disp_idx); end
        n_cmp++; if (disp_data !== 16'hCDEF) begin n_err++; $display("FAIL disp_sel_data got %h want cdef", disp_data); end
        disp_sel = 5'd0;
        tick();
        n_cmp++; if (disp_data !== 16'h0) begin n_err++; $display("FAIL disp_r0 got %h want 0", disp_data); end
    endtask

    task automatic test_auto_scan();
        int bad_idx;
        int exp;
        do_reset();
        write_word(5'd1, 32'h00001234, 4'hF);
        disp_auto = 1'b0;
        disp_sel = 5'd0;
        tick();
        disp_auto = 1'b1;
        bad_idx = 0;
        for (int n = 1; n <= 132; n++) begin
            tick();
            exp = (n / 4) % 32;
            n_cmp++;
            if (disp_idx !== ADDR_W'(exp)) begin
                n_err++;
                $display("FAIL scan_idx n=%0d got %0d want %0d", n, disp_idx, exp);
            end
            if (exp == 1) begin
                n_cmp++;
                if (disp_data !== 16'h1234) begin n_err++; $display("FAIL scan_data got %h want 1234", disp_data); end
            end
        end
        disp_auto = 1'b0;
        disp_sel = 5'd30;
        tick();
        disp_auto = 1'b1;
        repeat (4) tick();
        n_cmp++; if (disp_idx !== 5'd31) begin n_err++; $display("FAIL scan_from30 got %0d want 31", disp_idx); end
        repeat (4) tick();
        n_cmp++; if (disp_idx !== 5'd0) begin n_err++; $display("FAIL scan_wrap got %0d want 0", disp_idx); end
        disp_auto = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable_bypass();
        test_clear();
        test_back_to_back();
        test_reset_mid_clear();
        test_manual_disp();
        test_auto_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
